// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I instruction encoder.
// Takes decoded operation descriptors, packs them into legal 32-bit
// instruction words, queues them in a small FIFO and presents each word
// together with its byte address to the instruction-memory write port.
// Optional build macro: INSTR_ENC_RANGE_CHECK_EN -- when defined, immediates
// that do not fit their instruction format are rejected as illegal.
module instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [3:0]        in_alu_fun,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              addr_clr,
    output logic              err,
    input  logic              err_clr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Descriptor instruction classes
    localparam logic [3:0] CL_LUI    = 4'd0;
    localparam logic [3:0] CL_AUIPC  = 4'd1;
    localparam logic [3:0] CL_JAL    = 4'd2;
    localparam logic [3:0] CL_JALR   = 4'd3;
    localparam logic [3:0] CL_BRANCH = 4'd4;
    localparam logic [3:0] CL_LOAD   = 4'd5;
    localparam logic [3:0] CL_STORE  = 4'd6;
    localparam logic [3:0] CL_OP_IMM = 4'd7;
    localparam logic [3:0] CL_OP_RG3 = 4'd8;

    // Major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP_RG3 = 7'b0110011;

    // Pack a descriptor into its instruction word; unused fields stay zero.
    function automatic logic [31:0] encode(input logic [3:0] cls, input logic [3:0] fun,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [31:0] imm);
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] w;
        f3 = fun[2:0];
        f7 = {1'b0, fun[3], 5'b0};
        w  = '0;
        case (cls)
            CL_LUI:    w = {imm[31:12], rd, OPC_LUI};
            CL_AUIPC:  w = {imm[31:12], rd, OPC_AUIPC};
            CL_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            CL_JALR:   w = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            CL_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
            CL_LOAD:   w = {imm[11:0], rs1, f3, rd, OPC_LOAD};
            CL_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
            CL_OP_IMM: begin
                if (f3 == 3'b001 || f3 == 3'b101)
                    w = {f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM};
                else
                    w = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
            end
            CL_OP_RG3: w = {f7, rs2, rs1, f3, rd, OPC_OP_RG3};
            default:   w = '0;
        endcase
        return w;
    endfunction

    // True when the descriptor maps onto a real RV32I instruction.
    function automatic logic is_legal(input logic [3:0] cls, input logic [3:0] fun,
                                      input logic [31:0] imm);
        logic [2:0] f3;
        logic       ok;
        f3 = fun[2:0];
        ok = 1'b1;
        case (cls)
            CL_BRANCH: if (f3 == 3'b010 || f3 == 3'b011) ok = 1'b0;
            CL_LOAD:   if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ok = 1'b0;
            CL_STORE:  if (f3 >= 3'b011) ok = 1'b0;
            default:   if (cls > CL_OP_RG3) ok = 1'b0;
        endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
        // Immediate must be representable in the target format.
        case (cls)
            CL_LUI, CL_AUIPC: if (imm[11:0] != '0) ok = 1'b0;
            CL_JAL: if (!((imm[31:20] == '0 || imm[31:20] == '1) && !imm[0])) ok = 1'b0;
            CL_BRANCH: if (!((imm[31:12] == '0 || imm[31:12] == '1) && !imm[0])) ok = 1'b0;
            CL_JALR, CL_LOAD, CL_STORE: if (!(imm[31:11] == '0 || imm[31:11] == '1)) ok = 1'b0;
            CL_OP_IMM: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    if (imm[31:5] != '0) ok = 1'b0;
                end else if (!(imm[31:11] == '0 || imm[31:11] == '1)) begin
                    ok = 1'b0;
                end
            end
            default: ;
        endcase
`else
        if (imm == 32'hFFFF_FFFF && cls == 4'hF && fun == 4'hF) ok = 1'b0;
`endif
        return ok;
    endfunction

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    logic        full;
    logic        accept;
    logic        legal;
    logic        push;
    logic        pop;
    logic [31:0] enc_word;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_addr  = addr_q;
    assign err       = err_q;

    assign enc_word = encode(in_class, in_alu_fun, in_rd, in_rs1, in_rs2, in_imm);
    assign legal    = is_legal(in_class, in_alu_fun, in_imm);
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign pop      = out_valid && out_ready;

    // FIFO storage, pointers, occupancy, address counter and sticky error next-state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        addr_d   = addr_q;
        err_d    = err_q;
        if (push) begin
            mem_d[wr_ptr_q] = enc_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Reload has priority over advancing past a popped word.
        if (addr_clr)
            addr_d = ADDR_W'(BASE_ADDR);
        else if (pop)
            addr_d = addr_q + ADDR_W'(4);
        // A new drop overrides a clear in the same cycle.
        if (accept && !legal)
            err_d = 1'b1;
        else if (err_clr)
            err_d = 1'b0;
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= ADDR_W'(BASE_ADDR);
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    // FIFO payload storage; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a scoreboard queue holds the words
// expected at the output and a negedge monitor compares each pop against it.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready, in_ready4;
    logic [3:0]  in_class = '0;
    logic [3:0]  in_alu_fun = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid, out_valid4;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr, out_instr4;
    logic [15:0] out_addr;
    logic [3:0]  out_addr4;
    logic        addr_clr = 1'b0;
    logic        err, err4;
    logic        err_clr = 1'b0;

    int checks = 0;
    int fails  = 0;
    logic [31:0] sb [$];
    logic [15:0] exp_addr  = '0;
    logic [3:0]  exp_addr4 = '0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .ADDR_W(16), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_alu_fun(in_alu_fun), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .addr_clr(addr_clr), .err(err),
        .err_clr(err_clr)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_class(in_class), .in_alu_fun(in_alu_fun), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid4), .out_ready(out_ready),
        .out_instr(out_instr4), .out_addr(out_addr4), .addr_clr(addr_clr), .err(err4),
        .err_clr(err_clr)
    );

    // Scoreboard monitor: sampled mid-cycle, so it sees the inputs the next edge will act on.
    always @(negedge clk) begin
        logic [31:0] w;
        if (!rst_n) begin
            sb.delete();
            exp_addr  = '0;
            exp_addr4 = '0;
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_pop: unexpected word %08h, required none", out_instr);
                end else begin
                    w = sb.pop_front();
                    if (out_instr !== w) begin
                        fails++;
                        $display("FAIL sb_word: got %08h, required %08h", out_instr, w);
                    end
                end
                checks++;
                if (out_addr !== exp_addr) begin
                    fails++;
                    $display("FAIL sb_addr: got %04h, required %04h", out_addr, exp_addr);
                end
                checks++;
                if (out_addr4 !== exp_addr4 || out_instr4 !== out_instr) begin
                    fails++;
                    $display("FAIL sb_addr4: got %0h/%08h, required %0h/%08h",
                             out_addr4, out_instr4, exp_addr4, out_instr);
                end
                exp_addr  = exp_addr + 16'd4;
                exp_addr4 = exp_addr4 + 4'd4;
            end
            if (addr_clr) begin
                exp_addr  = '0;
                exp_addr4 = '0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one descriptor until it is accepted; log the expected word if legal.
    task automatic send(input logic [3:0] c, input logic [3:0] f, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                        input logic [31:0] w, input bit ok);
        int n = 0;
        in_class = c; in_alu_fun = f; in_rd = d; in_rs1 = s1; in_rs2 = s2; in_imm = im;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            step(1);
            n++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: in_ready stuck at 0, required 1");
        end else if (ok) begin
            sb.push_back(w);
        end
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(2);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin fails++; $display("FAIL rst_out_instr: got %08h, required 0", out_instr); end
        checks++; if (out_addr !== 16'h0) begin fails++; $display("FAIL rst_out_addr: got %04h, required 0", out_addr); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b, required 0", err); end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_addi;
        out_ready = 1'b1;
        send(4'd7, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h00500093 || out_addr !== 16'h0000) begin
            fails++;
            $display("FAIL addi_latency: got v=%b %08h @%04h, required v=1 00500093 @0000",
                     out_valid, out_instr, out_addr);
        end
        send(4'd7, 4'b0000, 5'd2, 5'd0, 5'd0, 32'd7, 32'h00700113, 1'b1);
        step(3);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL addi_drain: out_valid %b, required 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        send(4'd8, 4'b1000, 5'd3, 5'd1, 5'd2, 32'd0,         32'h402081B3, 1'b1); // SUB
        send(4'd7, 4'b1101, 5'd5, 5'd6, 5'd0, 32'd3,         32'h40335293, 1'b1); // SRAI
        send(4'd0, 4'b0000, 5'd7, 5'd0, 5'd0, 32'h12345000,  32'h123453B7, 1'b1); // LUI
        send(4'd2, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd8,         32'h008000EF, 1'b1); // JAL
        send(4'd4, 4'b0000, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,  32'hFE208EE3, 1'b1); // BEQ
        send(4'd6, 4'b0010, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020A423, 1'b1); // SW
        send(4'd5, 4'b0010, 5'd5, 5'd2, 5'd0, 32'd4,         32'h00412283, 1'b1); // LW
        send(4'd5, 4'b0100, 5'd1, 5'd0, 5'd0, 32'd0,         32'h00004083, 1'b1); // LBU
        send(4'd3, 4'b0111, 5'd1, 5'd5, 5'd0, 32'd0,         32'h000280E7, 1'b1); // JALR
        send(4'd1, 4'b0000, 5'd10, 5'd0, 5'd0, 32'hFFFFF000, 32'hFFFFF517, 1'b1); // AUIPC
        send(4'd7, 4'b0001, 5'd1, 5'd1, 5'd0, 32'd31,        32'h01F09093, 1'b1); // SLLI
        send(4'd7, 4'b1000, 5'd1, 5'd0, 5'd0, 32'd5,         32'h00500093, 1'b1); // ADDI, fun[3] ignored
        send(4'd7, 4'b0000, 5'd1, 5'd0, 5'd0, 32'hFFFFF800,  32'h80000093, 1'b1); // ADDI -2048
        step(3);
        checks++; if (sb.size() != 0) begin fails++; $display("FAIL b2b_left: %0d words pending, required 0", sb.size()); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL b2b_err: got %b, required 0", err); end
    endtask

    task automatic test_backpressure;
        logic [31:0] w;
        out_ready = 1'b0;
        addr_clr = 1'b1;
        step(1);
        addr_clr = 1'b0;
        checks++; if (out_addr !== 16'h0) begin fails++; $display("FAIL bp_clr: out_addr %04h, required 0000", out_addr); end
        for (int i = 1; i <= 4; i++) begin
            w = {12'(i), 5'd0, 3'd0, 5'(i), 7'h13};
            send(4'd7, 4'b0000, 5'(i), 5'd0, 5'd0, 32'(i), w, 1'b1);
        end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full: in_ready %b, required 0", in_ready); end
        in_class = 4'd7; in_alu_fun = 4'b0000; in_rd = 5'd5; in_rs1 = 5'd0; in_imm = 32'd5;
        in_valid = 1'b1;
        step(1);
        checks++; if (out_instr !== 32'h00100093) begin fails++; $display("FAIL bp_stable: out_instr %08h, required 00100093", out_instr); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold: in_ready %b, required 0", in_ready); end
        out_ready = 1'b1;
        step(1);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: in_ready %b, required 1", in_ready); end
        send(4'd7, 4'b0000, 5'd5, 5'd0, 5'd0, 32'd5, 32'h00500293, 1'b1);
        step(8);
        checks++; if (sb.size() != 0) begin fails++; $display("FAIL bp_left: %0d words pending, required 0", sb.size()); end
    endtask

    task automatic test_illegal;
        logic [3:0] cls [9] = '{4'd4, 4'd4, 4'd5, 4'd5, 4'd5, 4'd6, 4'd6, 4'd9, 4'd15};
        logic [3:0] fun [9] = '{4'd2, 4'd3, 4'd3, 4'd6, 4'd7, 4'd3, 4'd7, 4'd0, 4'd0};
        out_ready = 1'b1;
        send(4'd12, 4'b0000, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0, 1'b0);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL ill_class12: err %b, required 1", err); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ill_enq: out_valid %b, required 0", out_valid); end
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL ill_clr: err %b, required 0", err); end
        for (int i = 0; i < 9; i++) begin
            send(cls[i], fun[i], 5'd1, 5'd1, 5'd1, 32'd0, 32'h0, 1'b0);
            checks++;
            if (err !== 1'b1 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL ill_tab%0d: err=%b v=%b, required err=1 v=0", i, err, out_valid);
            end
            err_clr = 1'b1;
            step(1);
            err_clr = 1'b0;
        end
        err_clr = 1'b1;
        send(4'd10, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd0, 32'h0, 1'b0);
        err_clr = 1'b0;
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL ill_setwins: err %b, required 1", err); end
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        send(4'd7, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0, 1'b0);
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL range_2048: err %b, required 1", err); end
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
`else
        send(4'd7, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h80000093, 1'b1);
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL trunc_2048: err %b, required 0", err); end
`endif
        step(3);
        checks++; if (sb.size() != 0) begin fails++; $display("FAIL ill_left: %0d words pending, required 0", sb.size()); end
    endtask

    task automatic test_addr;
        out_ready = 1'b1;
        addr_clr = 1'b1;
        step(1);
        addr_clr = 1'b0;
        for (int i = 0; i < 5; i++)
            send(4'd7, 4'b0000, 5'd9, 5'd0, 5'd0, 32'(i), {12'(i), 5'd0, 3'd0, 5'd9, 7'h13}, 1'b1);
        step(3);
        checks++; if (out_addr4 !== 4'd4) begin fails++; $display("FAIL addr_wrap: out_addr4 %0h, required 4", out_addr4); end
        out_ready = 1'b0;
        send(4'd7, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 1'b1);
        send(4'd7, 4'b0000, 5'd2, 5'd0, 5'd0, 32'd2, 32'h00200113, 1'b1);
        out_ready = 1'b1;
        addr_clr = 1'b1;
        step(1);
        addr_clr = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_addr !== 16'h0) begin fails++; $display("FAIL addr_clr_pop: out_addr %04h, required 0000", out_addr); end
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL addr_noflush: out_valid %b, required 1", out_valid); end
        out_ready = 1'b1;
        step(3);
        checks++; if (sb.size() != 0) begin fails++; $display("FAIL addr_left: %0d words pending, required 0", sb.size()); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        send(4'd12, 4'b0000, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0, 1'b0);
        for (int i = 1; i <= 3; i++)
            send(4'd7, 4'b0000, 5'(i), 5'd0, 5'd0, 32'(i), {12'(i), 5'd0, 3'd0, 5'(i), 7'h13}, 1'b1);
        checks++; if (out_valid !== 1'b1 || err !== 1'b1) begin fails++; $display("FAIL mid_pre: v=%b err=%b, required 1 1", out_valid, err); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || in_ready !== 1'b1 || out_addr !== 16'h0 || err !== 1'b0) begin
            fails++;
            $display("FAIL mid_async: v=%b instr=%08h rdy=%b addr=%04h err=%b, required 0 0 1 0 0",
                     out_valid, out_instr, in_ready, out_addr, err);
        end
        step(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(2);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_empty: out_valid %b, required 0", out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_addi;
        test_back_to_back;
        test_backpressure;
        test_illegal;
        test_addr;
        test_reset_mid;
        checks++;
        if (sb.size() != 0) begin fails++; $display("FAIL final_sb: %0d words pending, required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder: the inverse of the pipeline's opcode/func3/func7 → control-signal decode.
- Accepts decoded operation descriptors (instruction class, alu_fun, register indices, full 32-bit immediate) over a valid/ready handshake.
- Packs each descriptor into a legal 32-bit instruction word and buffers it in a small FIFO.
- Emits {word, byte address} to the instruction-memory write port; used by the self-test/boot program generator.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- ADDR_W, 16, width of the output byte-address counter.
- BASE_ADDR, 0, counter value after reset or addr_clr; must be a multiple of 4.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- in_class  in  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP_RG3; 9-15 illegal
- in_alu_fun  in  4  {func7[5], func3}; func3 supplies branch/load/store width and condition
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  immediate, sign-extended byte offset or full value (U-type: upper 20 bits meaningful)
- out_valid  out  1  head entry valid
- out_ready  in  1  head consumed when out_valid && out_ready
- out_instr  out  32  encoded word at head
- out_addr  out  ADDR_W  byte address for out_instr
- addr_clr  in  1  synchronous reload of address counter to BASE_ADDR
- err  out  1  sticky: a descriptor was dropped
- err_clr  in  1  synchronous clear of err

Behaviour:
- Reset: FIFO empty, out_valid=0, out_instr=0, in_ready=1, out_addr=BASE_ADDR, err=0.
- Ready: in_ready = !full. No combinational path from out_ready to in_ready.
- Latency: word is written into the FIFO on the accept edge; out_valid asserts the next cycle when the FIFO was empty.
- Simultaneous push and pop: both take effect. When full, a pop frees space only from the next cycle.
- out_instr is stable while out_valid && !out_ready.
- Field placement (standard RV32I):
  - rd at [11:7], rs1 at [19:15], rs2 at [24:20], func3 = in_alu_fun[2:0].
  - Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111 (func3 forced 000), BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP_RG3 0110011.
  - Unused fields are zero: rs2 for I-type, rd for S/B-type.
- Formats:
  - OP_RG3: func7 = {1'b0, in_alu_fun[3], 5'b0}.
  - OP_IMM, func3 001/101: [31:25] = {1'b0, in_alu_fun[3], 5'b0}, [24:20] = imm[4:0].
  - OP_IMM, other func3: I-type imm[11:0]; in_alu_fun[3] ignored.
  - S/B/J: standard bit scrambling of imm. imm[0] ignored for B/J.
  - U: [31:12] = imm[31:12].
- Legality (always checked). These conditions drop the descriptor:
  - class 9-15;
  - BRANCH func3 010/011;
  - LOAD func3 011/110/111;
  - STORE func3 ≥011.
- Dropped descriptor: still handshaken (in_ready unaffected), nothing enqueued, err=1 from the next cycle.
- err_clr and a new error in the same cycle: err=1 (set wins).
- Address counter: +4 on each pop, wraps modulo 2^ADDR_W.
  - addr_clr loads BASE_ADDR and wins over a simultaneous pop.
  - addr_clr does not flush the FIFO.
- Async reset mid-stream: FIFO contents discarded immediately, all outputs return to reset values.

Optional Feature:
- Macro: INSTR_ENC_RANGE_CHECK_EN.
- Defined: immediates out of range are treated as illegal (dropped, err set). Ranges:
  - I/S: signed 12-bit [-2048, 2047];
  - shift shamt: 0-31;
  - B: signed 13-bit, even;
  - J: signed 21-bit, even;
  - U: imm[11:0] == 0.
- Undefined: no range check; immediate bits are truncated silently into their fields.

Test Plan:
- ADDI x1,x0,5 (class 7, alu_fun 0000, rd=1, rs1=0, imm=5), out_ready=1 → out_instr=0x00500093, out_addr=0x0000 one cycle after accept; next word at out_addr=0x0004.
- Back-to-back descriptors:
  - SUB x3,x1,x2 (class 8, alu_fun 1000) → 0x402081B3;
  - SRAI x5,x6,3 (class 7, alu_fun 1101, imm=3) → 0x40335293;
  - LUI x7, imm=0x12345000 → 0x123453B7.
- JAL x1, imm=+8 → 0x008000EF; BEQ x1,x2, imm=-4 (class 4, alu_fun 0000) → 0xFE208EE3.
- Backpressure, DEPTH=4, out_ready=0: push 5 descriptors → in_ready=0 after the 4th accept. Release out_ready → 4 words emerge in order at addresses 0,4,8,12, and in_ready=1 the cycle after the first pop.
- Illegal and range cases:
  - class 12 → nothing enqueued, err=1;
  - err_clr → err=0;
  - ADDI with imm=2048: with the macro, dropped and err=1; without the macro, 0x80000093 is emitted.
- Address and reset:
  - ADDR_W=4: 5 pops → out_addr sequence 0,4,8,12,0;
  - addr_clr with a simultaneous pop → out_addr=BASE_ADDR;
  - rst_n low mid-stream with 3 entries queued → out_valid=0 immediately, empty after release.
